csr_issue_arbiter: RTL and testbench

CSR_ISSUE_ARBITER -- requirements
Module: csr_issue_arbiter

---
 rtl/csr_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_csr_issue_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_issue_arbiter.sv
// Round-robin arbiter that picks one CSR requester, issues its latched access to
// the CSR buffer and holds ownership until commit, timeout or flush.
module csr_issue_arbiter #(
  parameter int NR_REQ         = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 64,
  localparam int IDW           = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int CW            = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NR_REQ-1:0]           req_valid_i,
  input  logic [NR_REQ-1:0][6:0]      req_op_i,
  input  logic [NR_REQ-1:0][11:0]     req_addr_i,
  input  logic [NR_REQ-1:0][XLEN-1:0] req_wdata_i,
  output logic [NR_REQ-1:0]           req_ready_o,
  output logic                        csr_valid_o,
  input  logic                        csr_ready_i,
  output logic [6:0]                  csr_op_o,
  output logic [11:0]                 csr_addr_o,
  output logic [XLEN-1:0]             csr_wdata_o,
  input  logic                        commit_i,
  output logic                        csr_commit_o,
  output logic [IDW-1:0]              grant_id_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_COMMIT = 2'd2
  } state_e;

  localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0]    ID_LAST  = IDW'(NR_REQ - 1);
  localparam logic [NR_REQ-1:0] ONE_HOT0 = {{(NR_REQ-1){1'b0}}, 1'b1};

  state_e            state_r, state_n;
  logic [IDW-1:0]    rr_ptr_r, rr_ptr_n;
  logic [CW-1:0]     cnt_r, cnt_n;
  logic [IDW-1:0]    grant_id_r;
  logic [6:0]        op_r;
  logic [11:0]       addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic              found_s;
  logic [IDW-1:0]    winner_s;
  logic              grant_s;
  logic              commit_s;
  logic              timeout_s;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (v == ID_LAST) ? '0 : v + IDW'(1);
  endfunction

  // Find the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int          idx_s;
    logic [IDW-1:0] cand_s;
    found_s  = 1'b0;
    winner_s = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx_s    = int'(rr_ptr_r) + i;
      idx_s    = (idx_s >= NR_REQ) ? idx_s - NR_REQ : idx_s;
      cand_s   = IDW'(idx_s);
      winner_s = (req_valid_i[cand_s] && !found_s) ? cand_s : winner_s;
      found_s  = found_s | req_valid_i[cand_s];
    end
  end

  assign grant_s = rst_ni && !flush_i && (state_r == IDLE) && found_s;

  // Next-state logic; flush overrides every other event and leaves rr_ptr alone.
  always_comb begin
    state_n   = state_r;
    rr_ptr_n  = rr_ptr_r;
    cnt_n     = cnt_r;
    commit_s  = 1'b0;
    timeout_s = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_n = ISSUE;
          end else begin
            state_n = IDLE;
          end
        end
        ISSUE: begin
          if (csr_ready_i) begin
            state_n = WAIT_COMMIT;
            cnt_n   = '0;
          end else begin
            state_n = ISSUE;
          end
        end
        WAIT_COMMIT: begin
          if (commit_i) begin
            commit_s = 1'b1;
            state_n  = IDLE;
            rr_ptr_n = wrap_inc(grant_id_r);
          end else if (cnt_r == CNT_LAST) begin
            timeout_s = 1'b1;
            state_n   = IDLE;
            rr_ptr_n  = wrap_inc(grant_id_r);
          end else begin
            cnt_n = cnt_r + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, pointer, counter and latched payload registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      grant_id_r <= '0;
      op_r       <= 7'd0;
      addr_r     <= 12'd0;
      wdata_r    <= '0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      cnt_r    <= cnt_n;
      if (grant_s) begin
        grant_id_r <= winner_s;
        op_r       <= req_op_i[winner_s];
        addr_r     <= req_addr_i[winner_s];
        wdata_r    <= req_wdata_i[winner_s];
      end
    end
  end

  // Reset gates every handshake output so nothing escapes while rst_ni is low.
  assign req_ready_o  = grant_s ? (ONE_HOT0 << winner_s) : '0;
  assign csr_valid_o  = rst_ni && (state_r == ISSUE);
  assign csr_commit_o = rst_ni && commit_s;
  assign timeout_o    = rst_ni && timeout_s;
  assign busy_o       = rst_ni && (state_r != IDLE);
  assign grant_id_o   = grant_id_r;
  assign csr_op_o     = op_r;
  assign csr_addr_o   = addr_r;
  assign csr_wdata_o  = wdata_r;

endmodule

// File: tb/tb_csr_issue_arbiter.sv
// Bench for csr_issue_arbiter: directed vector table, hand-written corner
// sequences, then random traffic checked against a transaction-level model.
module tb_csr_issue_arbiter;

  localparam int NR   = 2;
  localparam int TMO  = 4;
  localparam int XL   = 32;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic [NR-1:0]      valid;
  logic [NR-1:0][6:0] req_op;
  logic [NR-1:0][11:0] req_addr;
  logic [NR-1:0][XL-1:0] req_wdata;
  logic [NR-1:0]      ready;
  logic               csr_valid;
  logic               cready;
  logic [6:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XL-1:0]      csr_wdata;
  logic               commit;
  logic               csr_commit;
  logic [0:0]         gid;
  logic               busy;
  logic               tmo;

  csr_issue_arbiter #(.NR_REQ(NR), .TIMEOUT_CYCLES(TMO), .XLEN(XL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(valid), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_ready_o(ready),
    .csr_valid_o(csr_valid), .csr_ready_i(cready),
    .csr_op_o(csr_op), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .commit_i(commit), .csr_commit_o(csr_commit),
    .grant_id_o(gid), .busy_o(busy), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the buffer, has it been issued, how long waited.
  bit          m_busy, m_issued;
  int          m_owner, m_ptr, m_wait;
  logic [6:0]  m_op;
  logic [11:0] m_addr;
  logic [XL-1:0] m_wd;

  function automatic int pick();
    for (int k = 0; k < NR; k++) begin
      if (valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
      m_op = 7'd0; m_addr = 12'd0; m_wd = '0;
    end else if (flush) begin
      m_busy = 0; m_issued = 0;
    end else if (!m_busy) begin
      w = pick();
      if (w >= 0) begin
        m_owner = w; m_op = req_op[w]; m_addr = req_addr[w]; m_wd = req_wdata[w];
        m_busy = 1; m_issued = 0;
      end
    end else if (!m_issued) begin
      if (cready) begin m_issued = 1; m_wait = 0; end
    end else if (commit || m_wait == TMO - 1) begin
      m_busy = 0; m_issued = 0; m_ptr = (m_owner + 1) % NR;
    end else begin
      m_wait++;
    end
  endtask

  task automatic model_check();
    int w;
    logic [NR-1:0] e_ready;
    w = pick();
    e_ready = (rst_n && !flush && !m_busy && w >= 0) ? NR'(1 << w) : '0;
    chk("rnd ready", 64'(ready), 64'(e_ready));
    chk("rnd csr_valid", 64'(csr_valid), 64'(rst_n && m_busy && !m_issued));
    chk("rnd csr_commit", 64'(csr_commit), 64'(rst_n && m_busy && m_issued && commit && !flush));
    chk("rnd timeout", 64'(tmo), 64'(rst_n && m_busy && m_issued && !commit && !flush && m_wait == TMO - 1));
    chk("rnd busy", 64'(busy), 64'(rst_n && m_busy));
    if (rst_n) chk("rnd grant_id", 64'(gid), 64'(m_owner));
    if (rst_n && m_busy) begin
      chk("rnd addr", 64'(csr_addr), 64'(m_addr));
      chk("rnd op", 64'(csr_op), 64'(m_op));
      chk("rnd wdata", 64'(csr_wdata), 64'(m_wd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic rst_n, flush; logic [1:0] valid; logic cready, commit;
    logic [1:0] e_ready; logic e_cvalid, e_commit, e_tmo, e_busy, chk_gid, e_gid;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic [1:0] v, input logic cr,
                     input logic cm, input logic [1:0] er, input logic ecv, input logic ecm,
                     input logic etm, input logic eb, input logic cg, input logic eg);
    vec_t t;
    t = '{r, f, v, cr, cm, er, ecv, ecm, etm, eb, cg, eg};
    vq.push_back(t);
  endtask

  logic [NR-1:0] pend;
  logic [NR-1:0] e_rdy;
  logic [11:0]   held_addr;
  int            exp_id;

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = '0; cready = 1'b0; commit = 1'b0;
    req_op[0] = 7'h01; req_addr[0] = 12'h300; req_wdata[0] = 32'h0000_000A;
    req_op[1] = 7'h02; req_addr[1] = 12'h341; req_wdata[1] = 32'h0000_000B;
    //  rst flush valid crdy cmt | ready cval cmt tmo busy chkid id
    add(0, 0, 2'b01, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2'b01, 0, 0,  2'b01, 0, 0, 0, 0, 1, 0);
    add(1, 0, 2'b00, 0, 1,  2'b00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 1, 0,  2'b00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 0, 1,  2'b00, 0, 1, 0, 1, 1, 0);
    add(1, 0, 2'b11, 0, 0,  2'b10, 0, 0, 0, 0, 1, 0);
    add(1, 0, 2'b01, 1, 0,  2'b00, 1, 0, 0, 1, 1, 1);
    add(1, 1, 2'b01, 0, 1,  2'b00, 0, 0, 0, 1, 1, 1);
    add(1, 0, 2'b11, 0, 0,  2'b10, 0, 0, 0, 0, 1, 1);
    add(1, 1, 2'b01, 0, 0,  2'b00, 1, 0, 0, 1, 1, 1);
    add(1, 1, 2'b01, 0, 1,  2'b00, 0, 0, 0, 0, 1, 1);
    add(1, 0, 2'b01, 0, 0,  2'b01, 0, 0, 0, 0, 1, 1);
    add(1, 0, 2'b00, 1, 0,  2'b00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 1, 0);
    add(1, 0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 1, 1, 0);
    add(1, 0, 2'b11, 0, 0,  2'b10, 0, 0, 0, 0, 1, 0);
    add(0, 0, 2'b01, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2'b01, 0, 0,  2'b01, 0, 0, 0, 0, 1, 0);
    add(1, 0, 2'b00, 0, 0,  2'b00, 1, 0, 0, 1, 1, 0);

    @(negedge clk);
    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; flush = vq[i].flush; valid = vq[i].valid;
      cready = vq[i].cready; commit = vq[i].commit;
      #1;
      chk($sformatf("row%0d ready", i), 64'(ready), 64'(vq[i].e_ready));
      chk($sformatf("row%0d csr_valid", i), 64'(csr_valid), 64'(vq[i].e_cvalid));
      chk($sformatf("row%0d csr_commit", i), 64'(csr_commit), 64'(vq[i].e_commit));
      chk($sformatf("row%0d timeout", i), 64'(tmo), 64'(vq[i].e_tmo));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(vq[i].e_busy));
      if (vq[i].chk_gid) chk($sformatf("row%0d grant_id", i), 64'(gid), 64'(vq[i].e_gid));
      if (vq[i].e_cvalid)
        chk($sformatf("row%0d addr", i), 64'(csr_addr), 64'(req_addr[vq[i].e_gid]));
      tick();
    end

    // Backpressure: requester 0 is in ISSUE; payload must hold for 5 stalled cycles.
    valid = 2'b00; cready = 1'b0; commit = 1'b0;
    held_addr = 12'h300;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d csr_valid", c), 64'(csr_valid), 64'd1);
      chk($sformatf("bp%0d addr", c), 64'(csr_addr), 64'(held_addr));
      chk($sformatf("bp%0d op", c), 64'(csr_op), 64'h01);
      chk($sformatf("bp%0d wdata", c), 64'(csr_wdata), 64'h0A);
      tick();
    end
    cready = 1'b1; #1; chk("bp accept csr_valid", 64'(csr_valid), 64'd1); tick();
    cready = 1'b0; commit = 1'b1; #1; chk("bp commit", 64'(csr_commit), 64'd1); tick();
    commit = 1'b0;

    // Contention: both requesters held; owner 0 just committed so grants go 1,0,1,0.
    exp_id = 1;
    for (int g = 0; g < 4; g++) begin
      valid = 2'b11; #1;
      chk($sformatf("rr%0d ready", g), 64'(ready), 64'(1 << exp_id));
      tick();
      valid = 2'b11 & ~(2'(1) << exp_id); cready = 1'b1; #1;
      chk($sformatf("rr%0d grant_id", g), 64'(gid), 64'(exp_id));
      chk($sformatf("rr%0d csr_valid", g), 64'(csr_valid), 64'd1);
      tick();
      cready = 1'b0; commit = 1'b1; #1;
      chk($sformatf("rr%0d commit", g), 64'(csr_commit), 64'd1);
      tick();
      commit = 1'b0;
      exp_id = 1 - exp_id;
    end

    // Random traffic against the model, starting from a clean reset.
    valid = '0; rst_n = 1'b0; #1; tick();
    pend = '0;
    for (int n = 0; n < 4000; n++) begin
      rst_n  = ($urandom % 100) != 0;
      flush  = ($urandom % 20) == 0;
      cready = $urandom % 2;
      commit = ($urandom % 4) == 0;
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && ($urandom % 3) == 0) begin
          pend[r] = 1'b1;
          req_op[r] = 7'($urandom); req_addr[r] = 12'($urandom); req_wdata[r] = $urandom;
        end
      end
      valid = pend;
      #1;
      model_check();
      e_rdy = (rst_n && !flush && !m_busy && pick() >= 0) ? NR'(1 << pick()) : '0;
      tick();
      pend = pend & ~e_rdy;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
